// File: rtl/sprite_queue.sv
// sprite_queue: packs 6-byte sprite records from a byte stream into a show-ahead FIFO.
// fb_resetting flushes the queue and any partial record.
module sprite_queue #(
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     fb_resetting,
    input  logic                     in_valid,
    input  logic                     in_sof,
    input  logic [7:0]               in_byte,
    output logic                     in_ready,
    input  logic                     sprite_queue_dequeue,
    output logic                     sprite_queue_is_empty,
    output logic [7:0]               sprite_queue_sprite_id,
    output logic [15:0]              sprite_queue_sprite_x,
    output logic [15:0]              sprite_queue_sprite_y,
    output logic [7:0]               sprite_queue_sprite_scale,
    output logic [$clog2(DEPTH):0]   queue_count,
    output logic                     queue_full,
    output logic                     framing_error
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [2:0] {B0, B1, B2, B3, B4, B5} idx_t;
    idx_t idx, idx_next;
    logic [4:0][7:0] hold;
    logic [47:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [2:0] pos;
    logic accept, push, pop;
    assign queue_full = queue_count == (AW+1)'(DEPTH);
    assign sprite_queue_is_empty = queue_count == '0;
    assign in_ready = !(idx == B5 && queue_full) && !fb_resetting;
    assign accept = in_valid && in_ready;
    assign push = accept && !in_sof && idx == B5;
    assign pop = sprite_queue_dequeue && !sprite_queue_is_empty;
    assign {sprite_queue_sprite_id, sprite_queue_sprite_x, sprite_queue_sprite_y,
            sprite_queue_sprite_scale} = sprite_queue_is_empty ? 48'd0 : mem[rd_ptr];
    // in_sof resyncs: the byte becomes byte 0 regardless of where the packer was
    always_comb begin
        idx_next = idx;
        pos = in_sof ? 3'd0 : idx;
        if (accept) idx_next = in_sof ? B1 : idx == B5 ? B0 : idx_t'(idx + 3'd1);
    end
    always_ff @(posedge clock or posedge fb_resetting) begin
        if (fb_resetting) begin
            idx <= B0;
            framing_error <= 1'b0;
            hold <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            queue_count <= '0;
        end else begin
            idx <= idx_next;
            if (accept && in_sof && idx != B0) framing_error <= 1'b1;
            if (accept && !push) hold[pos] <= in_byte;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            queue_count <= queue_count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= {hold[0], hold[1], hold[2], hold[3], hold[4], in_byte};
    end
endmodule

// File: tb/tb_sprite_queue.sv
// tb_sprite_queue: directed tests for the sprite record packer and queue.
module tb_sprite_queue;
    logic clock = 0, fb_resetting = 1, in_valid = 0, in_sof = 0, deq = 0;
    logic [7:0] in_byte = 0;
    logic in_ready, is_empty, queue_full, framing_error;
    logic [7:0] id, scale;
    logic [15:0] x, y;
    logic [4:0] count;
    int tests = 0, fails = 0;

    sprite_queue #(.DEPTH(16)) dut (
        .clock(clock), .fb_resetting(fb_resetting), .in_valid(in_valid), .in_sof(in_sof),
        .in_byte(in_byte), .in_ready(in_ready), .sprite_queue_dequeue(deq),
        .sprite_queue_is_empty(is_empty), .sprite_queue_sprite_id(id),
        .sprite_queue_sprite_x(x), .sprite_queue_sprite_y(y),
        .sprite_queue_sprite_scale(scale), .queue_count(count),
        .queue_full(queue_full), .framing_error(framing_error)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic put(input logic [7:0] b, input logic s);
        @(negedge clock);
        in_valid = 1; in_byte = b; in_sof = s;
        @(posedge clock); #1;
        in_valid = 0; in_sof = 0;
    endtask

    task automatic put_rec(input logic [7:0] i, input logic [15:0] px, input logic [15:0] py,
                           input logic [7:0] s, input logic sof);
        put(i, sof); put(px[15:8], 0); put(px[7:0], 0);
        put(py[15:8], 0); put(py[7:0], 0); put(s, 0);
    endtask

    task automatic pop();
        @(negedge clock);
        deq = 1;
        @(posedge clock); #1;
        deq = 0;
    endtask

    task automatic test_reset();
        #12;
        tests++; if (is_empty !== 1'b1) begin fails++; $display("FAIL reset_empty got %b want 1", is_empty); end
        tests++; if (count !== 5'd0) begin fails++; $display("FAIL reset_count got %0d want 0", count); end
        tests++; if (queue_full !== 1'b0) begin fails++; $display("FAIL reset_full got %b want 0", queue_full); end
        tests++; if ({id, x, y, scale} !== 48'd0) begin fails++; $display("FAIL reset_fields got %h want 0", {id, x, y, scale}); end
        tests++; if (framing_error !== 1'b0) begin fails++; $display("FAIL reset_ferr got %b want 0", framing_error); end
        @(negedge clock); fb_resetting = 0;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", in_ready); end
    endtask

    task automatic test_basic();
        put_rec(8'h07, 16'h012C, 16'h0064, 8'h10, 1);
        @(negedge clock);
        tests++; if (is_empty !== 1'b0) begin fails++; $display("FAIL basic_empty got %b want 0", is_empty); end
        tests++; if (id !== 8'h07) begin fails++; $display("FAIL basic_id got %h want 07", id); end
        tests++; if (x !== 16'd300) begin fails++; $display("FAIL basic_x got %0d want 300", x); end
        tests++; if (y !== 16'd100) begin fails++; $display("FAIL basic_y got %0d want 100", y); end
        tests++; if (scale !== 8'h10) begin fails++; $display("FAIL basic_scale got %h want 10", scale); end
        tests++; if (count !== 5'd1) begin fails++; $display("FAIL basic_count got %0d want 1", count); end
        pop();
        @(negedge clock);
        tests++; if (is_empty !== 1'b1) begin fails++; $display("FAIL basic_pop_empty got %b want 1", is_empty); end
        tests++; if ({id, x, y, scale} !== 48'd0) begin fails++; $display("FAIL basic_pop_fields got %h want 0", {id, x, y, scale}); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 16; i++) put_rec(8'(i), 16'(i * 3), 16'(i * 5), 8'(i + 1), 0);
        @(negedge clock);
        tests++; if (count !== 5'd16) begin fails++; $display("FAIL full_count got %0d want 16", count); end
        tests++; if (queue_full !== 1'b1) begin fails++; $display("FAIL full_flag got %b want 1", queue_full); end
        tests++; if (id !== 8'd0) begin fails++; $display("FAIL full_head got %0d want 0", id); end
        put(8'd16, 1); put(8'h00, 0); put(8'h30, 0); put(8'h00, 0); put(8'h50, 0);
        @(negedge clock);
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL full_ready_idx5 got %b want 0", in_ready); end
        tests++; if (count !== 5'd16) begin fails++; $display("FAIL full_hold_count got %0d want 16", count); end
        in_valid = 1; in_byte = 8'h17; deq = 1;
        @(posedge clock); #1;
        deq = 0;
        @(negedge clock);
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL full_ready_after_pop got %b want 1", in_ready); end
        tests++; if (count !== 5'd15) begin fails++; $display("FAIL full_count_after_pop got %0d want 15", count); end
        @(posedge clock); #1;
        in_valid = 0;
        @(negedge clock);
        tests++; if (count !== 5'd16) begin fails++; $display("FAIL full_count_17th got %0d want 16", count); end
        tests++; if (id !== 8'd1) begin fails++; $display("FAIL full_head_after got %0d want 1", id); end
        for (int i = 1; i <= 16; i++) begin
            @(negedge clock);
            tests++; if (id !== 8'(i)) begin fails++; $display("FAIL full_drain_id got %0d want %0d", id, i); end
            pop();
        end
        @(negedge clock);
        tests++; if (scale !== 8'h00 || is_empty !== 1'b1) begin fails++; $display("FAIL full_drained got empty=%b want 1", is_empty); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 3; i++) put_rec(8'(i), 16'hA000 + 16'(i), 16'h0, 8'h1, 0);
        for (int i = 3; i < 43; i++) begin
            @(negedge clock);
            tests++; if (id !== 8'(i - 3)) begin fails++; $display("FAIL wrap_order got %0d want %0d", id, i - 3); end
            tests++; if (x !== 16'hA000 + 16'(i - 3)) begin fails++; $display("FAIL wrap_x got %h want %h", x, 16'hA000 + 16'(i - 3)); end
            pop();
            if (i < 40) begin
                put_rec(8'(i), 16'hA000 + 16'(i), 16'h0, 8'h1, 0);
                @(negedge clock);
                tests++; if (count !== 5'd3) begin fails++; $display("FAIL wrap_count got %0d want 3", count); end
            end
        end
        @(negedge clock);
        tests++; if (is_empty !== 1'b1) begin fails++; $display("FAIL wrap_end_empty got %b want 1", is_empty); end
    endtask

    task automatic test_back_to_back();
        put_rec(8'hA1, 16'h1111, 16'h2222, 8'h33, 1);
        put(8'hB2, 1); put(8'h44, 0); put(8'h55, 0); put(8'h66, 0); put(8'h77, 0);
        @(negedge clock);
        tests++; if (id !== 8'hA1) begin fails++; $display("FAIL b2b_head_before got %h want a1", id); end
        in_valid = 1; in_byte = 8'h88; deq = 1;
        @(posedge clock); #1;
        in_valid = 0; deq = 0;
        @(negedge clock);
        tests++; if (count !== 5'd1) begin fails++; $display("FAIL b2b_count got %0d want 1", count); end
        tests++; if (is_empty !== 1'b0) begin fails++; $display("FAIL b2b_empty got %b want 0", is_empty); end
        tests++; if ({id, x, y, scale} !== 48'hB2_4455_6677_88) begin fails++; $display("FAIL b2b_head got %h want b24455667788", {id, x, y, scale}); end
        pop();
    endtask

    task automatic test_framing();
        put(8'hEE, 1); put(8'hEE, 0); put(8'hEE, 0);
        @(negedge clock);
        tests++; if (framing_error !== 1'b0) begin fails++; $display("FAIL frame_before got %b want 0", framing_error); end
        put_rec(8'hC3, 16'h1234, 16'h5678, 8'h9A, 1);
        @(negedge clock);
        tests++; if (framing_error !== 1'b1) begin fails++; $display("FAIL frame_err got %b want 1", framing_error); end
        tests++; if (count !== 5'd1) begin fails++; $display("FAIL frame_count got %0d want 1", count); end
        tests++; if ({id, x, y, scale} !== 48'hC3_1234_5678_9A) begin fails++; $display("FAIL frame_rec got %h want c3123456789a", {id, x, y, scale}); end
        pop();
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) put_rec(8'h50 + 8'(i), 16'h0, 16'h0, 8'h0, 1);
        put(8'hDD, 1); put(8'hDD, 0); put(8'hDD, 0);
        @(negedge clock);
        tests++; if (count !== 5'd5) begin fails++; $display("FAIL areset_pre_count got %0d want 5", count); end
        #2 fb_resetting = 1;
        #1;
        tests++; if (is_empty !== 1'b1) begin fails++; $display("FAIL areset_empty got %b want 1", is_empty); end
        tests++; if (count !== 5'd0) begin fails++; $display("FAIL areset_count got %0d want 0", count); end
        tests++; if (framing_error !== 1'b0) begin fails++; $display("FAIL areset_ferr got %b want 0", framing_error); end
        tests++; if (id !== 8'h00) begin fails++; $display("FAIL areset_id got %h want 00", id); end
        @(negedge clock); fb_resetting = 0;
        pop();
        @(negedge clock);
        tests++; if (count !== 5'd0 || is_empty !== 1'b1) begin fails++; $display("FAIL areset_empty_pop got count=%0d want 0", count); end
        put_rec(8'h61, 16'hABCD, 16'h0102, 8'h33, 0);
        @(negedge clock);
        tests++; if (count !== 5'd1) begin fails++; $display("FAIL areset_next_count got %0d want 1", count); end
        tests++; if ({id, x, y, scale} !== 48'h61_ABCD_0102_33) begin fails++; $display("FAIL areset_next_rec got %h want 61abcd010233", {id, x, y, scale}); end
        tests++; if (framing_error !== 1'b0) begin fails++; $display("FAIL areset_next_ferr got %b want 0", framing_error); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_wrap();
        test_back_to_back();
        test_framing();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
